toysram_16x12_ctl: RTL
======================

Name: toysram_16x12_ctl

Overview:
Sequencing and read-eval front end for one 16x12 10T 2R1W toysram subarray (cells only, no eval circuit). Accepts one request per transaction carrying up to two reads and one write. Decodes addresses into one-hot wordlines and drives the write bitline pair. Precharges and samples the read bitlines and returns registered read data. Sits directly upstream of the subarray and directly downstream of the test-site/host interface logic.

Parameters:
EVAL_CYC, 2, cycles wordlines held before read bitlines are sampled (1..15)
WR_CYC, 2, cycles write wordline and bitlines are held (1..15)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
req_val  input  1  request valid
req_rdy  output  1  controller idle, request accepted when req_val & req_rdy
rd0_val  input  1  port-0 read enable for this request
rd0_adr  input  [0:3]  port-0 row address
rd1_val  input  1  port-1 read enable
rd1_adr  input  [0:3]  port-1 row address
wr_val  input  1  write enable
wr_adr  input  [0:3]  write row address
wr_dat  input  [0:11]  write data
rd_done  output  1  one-cycle pulse, read data valid
rd0_dat  output  [0:11]  port-0 read data
rd1_dat  output  [0:11]  port-1 read data
rbl_pre  output  1  read bitline precharge enable (active-high)
RWL0  output  [0:15]  port-0 read wordlines to array
RWL1  output  [0:15]  port-1 read wordlines to array
WWL  output  [0:15]  write wordlines to array
WBL  output  [0:11]  write bitline
WBLb  output  [0:11]  write bitline complement
RBL0  input  [0:11]  port-0 read bitlines from array
RBL1  input  [0:11]  port-1 read bitlines from array

Behaviour:
- One clock (clk); reset is synchronous and active-high; all state and outputs are registered.
- Reset values: state IDLE; req_rdy=1; rbl_pre=1; rd_done=0; rd0_dat=rd1_dat=0; RWL0=RWL1=WWL=0; WBL=WBLb=0.
- States: IDLE, EVAL, CAPT, WRITE.
- IDLE:
  - req_rdy=1 and rbl_pre=1; all wordlines 0.
  - On accept, capture all request fields.
  - If rd0_val or rd1_val -> EVAL.
  - Else if wr_val -> WRITE.
  - Else the request is a no-op and the state stays IDLE.
- EVAL:
  - rbl_pre=0.
  - RWL0 is one-hot at bit rd0_adr if rd0_val, else 0; RWL1 likewise from rd1_adr.
  - A cycle counter runs EVAL_CYC cycles, then -> CAPT.
- CAPT:
  - Wordlines held, rbl_pre=0.
  - At the end of the cycle: rd0_dat <= ~RBL0 if rd0_val, else 0; rd1_dat <= ~RBL1 if rd1_val, else 0. A discharged bitline reads as 1.
  - rd_done pulses high in the following cycle.
  - Next state: WRITE if wr_val, else IDLE.
- WRITE:
  - RWL0=RWL1=0; rbl_pre=1.
  - WWL is one-hot at bit wr_adr; WBL=wr_dat, WBLb=~wr_dat.
  - Held WR_CYC cycles, then -> IDLE.
  - Outside WRITE, WWL=0 and WBL=WBLb=0.
- Ordering:
  - Reads always complete before the write within a request.
  - A read and a write to the same row return the old contents.
  - rd0_adr may equal rd1_adr; both wordlines assert and both ports return the same row.
- Latency (accept at cycle 0, read present):
  - EVAL spans cycles 1..EVAL_CYC; CAPT is cycle EVAL_CYC+1.
  - rd_done is high in cycle EVAL_CYC+2.
  - With no write, req_rdy returns in cycle EVAL_CYC+2.
  - A write-only request occupies cycles 1..WR_CYC; req_rdy returns in cycle WR_CYC+1.
- rd0_dat/rd1_dat hold their value until the next CAPT or reset.
- req_val is ignored while req_rdy=0; no queuing.
- Reset mid-operation: at the next edge, wordlines drop to 0, WBL/WBLb go to 0 and the state goes to IDLE. No rd_done is issued and any partial write is abandoned.

Optional Feature:
TOYSRAM_WR_BYPASS_EN
- Defined: in CAPT, a read port whose address equals wr_adr with wr_val=1 returns wr_dat (the new data) instead of the sampled bitlines. The array write sequence is unchanged.
- Undefined: reads always return the sampled bitlines, i.e. the old data.

Test Plan:
- Reset: assert reset 2 cycles -> req_rdy=1, rbl_pre=1, all wordlines and WBL/WBLb=0, rd0_dat=rd1_dat=0, rd_done=0.
- Write-only, wr_adr=5, wr_dat=0xA5C, EVAL_CYC=2, WR_CYC=2 -> WWL=0x0400 (bit 5) for cycles 1-2, WBL=0xA5C, WBLb=0x5A3, req_rdy=1 in cycle 3.
- Dual read, rd0_adr=5, rd1_adr=9, array model holding 0xA5C/0x123 -> RWL0 bit 5 and RWL1 bit 9 high cycles 1-3, rd_done in cycle 4, rd0_dat=0xA5C, rd1_dat=0x123.
- Read+write same row 5 (old 0xA5C, new 0x3F0) -> rd0_dat=0xA5C with macro undefined, 0x3F0 with TOYSRAM_WR_BYPASS_EN; array row 5=0x3F0 after WRITE in both builds.
- req_val held high across back-to-back requests -> second request accepted only in the cycle req_rdy=1; no request dropped or double-accepted.
- Reset asserted in EVAL cycle 1 -> next cycle RWL0=RWL1=0, state IDLE, no rd_done pulse, rd0_dat unchanged at 0.

Source files
------------

// File: rtl/toysram_16x12_ctl.sv
// Sequencing/read-eval controller for one 16x12 2R1W toysram subarray.
// Optional define TOYSRAM_WR_BYPASS_EN: same-row reads return the new write data.
module toysram_16x12_ctl #(
  parameter int unsigned EVAL_CYC = 2,
  parameter int unsigned WR_CYC   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_val,
  output logic        req_rdy,
  input  logic        rd0_val,
  input  logic [0:3]  rd0_adr,
  input  logic        rd1_val,
  input  logic [0:3]  rd1_adr,
  input  logic        wr_val,
  input  logic [0:3]  wr_adr,
  input  logic [0:11] wr_dat,
  output logic        rd_done,
  output logic [0:11] rd0_dat,
  output logic [0:11] rd1_dat,
  output logic        rbl_pre,
  output logic [0:15] RWL0,
  output logic [0:15] RWL1,
  output logic [0:15] WWL,
  output logic [0:11] WBL,
  output logic [0:11] WBLb,
  input  logic [0:11] RBL0,
  input  logic [0:11] RBL1
);

  typedef enum logic [1:0] {IDLE, EVAL, CAPT, WRITE} state_e;

  localparam logic [3:0] EVAL_LAST = 4'(EVAL_CYC - 1);
  localparam logic [3:0] WR_LAST   = 4'(WR_CYC - 1);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        rd0_val_q, rd1_val_q, wr_val_q;
  logic [0:3]  rd0_adr_q, rd1_adr_q, wr_adr_q;
  logic [0:11] wr_dat_q;
  logic        req_rdy_q, rbl_pre_q, rd_done_q;
  logic [0:11] rd0_dat_q, rd1_dat_q, rd0_dat_d, rd1_dat_d;
  logic [0:15] rwl0_q, rwl1_q, wwl_q;
  logic [0:11] wbl_q, wblb_q;

  function automatic logic [0:15] onehot16(input logic [0:3] a);
    logic [0:15] r;
    r    = '0;
    r[a] = 1'b1;
    return r;
  endfunction

  // Bitlines discharge for a stored 1, so sampled data is inverted.
  always_comb begin
    rd0_dat_d = rd0_val_q ? ~RBL0 : '0;
    rd1_dat_d = rd1_val_q ? ~RBL1 : '0;
`ifdef TOYSRAM_WR_BYPASS_EN
    if (rd0_val_q && wr_val_q && (rd0_adr_q == wr_adr_q)) rd0_dat_d = wr_dat_q;
    if (rd1_val_q && wr_val_q && (rd1_adr_q == wr_adr_q)) rd1_dat_d = wr_dat_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rd0_val_q <= 1'b0;
      rd1_val_q <= 1'b0;
      wr_val_q  <= 1'b0;
      rd0_adr_q <= '0;
      rd1_adr_q <= '0;
      wr_adr_q  <= '0;
      wr_dat_q  <= '0;
      req_rdy_q <= 1'b1;
      rbl_pre_q <= 1'b1;
      rd_done_q <= 1'b0;
      rd0_dat_q <= '0;
      rd1_dat_q <= '0;
      rwl0_q    <= '0;
      rwl1_q    <= '0;
      wwl_q     <= '0;
      wbl_q     <= '0;
      wblb_q    <= '0;
    end else begin
      rd_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_val) begin
            rd0_val_q <= rd0_val;
            rd1_val_q <= rd1_val;
            wr_val_q  <= wr_val;
            rd0_adr_q <= rd0_adr;
            rd1_adr_q <= rd1_adr;
            wr_adr_q  <= wr_adr;
            wr_dat_q  <= wr_dat;
            if (rd0_val || rd1_val) begin
              state_q   <= EVAL;
              req_rdy_q <= 1'b0;
              rbl_pre_q <= 1'b0;
              rwl0_q    <= rd0_val ? onehot16(rd0_adr) : '0;
              rwl1_q    <= rd1_val ? onehot16(rd1_adr) : '0;
              cnt_q     <= EVAL_LAST;
            end else if (wr_val) begin
              state_q   <= WRITE;
              req_rdy_q <= 1'b0;
              wwl_q     <= onehot16(wr_adr);
              wbl_q     <= wr_dat;
              wblb_q    <= ~wr_dat;
              cnt_q     <= WR_LAST;
            end
          end
        end
        EVAL: begin
          if (cnt_q == '0) state_q <= CAPT;
          else             cnt_q   <= cnt_q - 4'd1;
        end
        CAPT: begin
          rd0_dat_q <= rd0_dat_d;
          rd1_dat_q <= rd1_dat_d;
          rd_done_q <= 1'b1;
          rwl0_q    <= '0;
          rwl1_q    <= '0;
          rbl_pre_q <= 1'b1;
          if (wr_val_q) begin
            state_q <= WRITE;
            wwl_q   <= onehot16(wr_adr_q);
            wbl_q   <= wr_dat_q;
            wblb_q  <= ~wr_dat_q;
            cnt_q   <= WR_LAST;
          end else begin
            state_q   <= IDLE;
            req_rdy_q <= 1'b1;
          end
        end
        WRITE: begin
          if (cnt_q == '0) begin
            state_q   <= IDLE;
            req_rdy_q <= 1'b1;
            wwl_q     <= '0;
            wbl_q     <= '0;
            wblb_q    <= '0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_rdy = req_rdy_q;
  assign rbl_pre = rbl_pre_q;
  assign rd_done = rd_done_q;
  assign rd0_dat = rd0_dat_q;
  assign rd1_dat = rd1_dat_q;
  assign RWL0    = rwl0_q;
  assign RWL1    = rwl1_q;
  assign WWL     = wwl_q;
  assign WBL     = wbl_q;
  assign WBLb    = wblb_q;

endmodule
